// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption core: one cipher round per clock.
// Round keys are fetched from an external schedule by round index.
module aes_round_sequencer #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   key_round,
    output logic         key_req,
    input  logic         key_valid,
    input  logic [127:0] key_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [3:0] LP_NR = 4'(NR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDK0,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t       r_fsm;
    logic [3:0]   r_cnt;
    logic [127:0] r_state;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_key_req;
    logic         r_busy;

    logic [127:0] w_sb;
    logic [127:0] w_sr;
    logic [127:0] w_mc;
    logic [127:0] w_round_full;
    logic [127:0] w_round_last;

    function automatic logic [7:0] f_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] f_gmul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] v_p;
        logic [7:0] v_a;
        v_p = 8'h00;
        v_a = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) v_p = v_p ^ v_a;
            v_a = f_xtime(v_a);
        end
        return v_p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine map;
    // zero maps to zero before the affine step.
    function automatic logic [7:0] f_sbox(input logic [7:0] a);
        logic [7:0] v_sq;
        logic [7:0] v_i;
        v_sq = a;
        v_i  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            v_sq = f_gmul(v_sq, v_sq);
            v_i  = f_gmul(v_i, v_sq);
        end
        return v_i ^ {v_i[6:0], v_i[7]} ^ {v_i[5:0], v_i[7:6]}
             ^ {v_i[4:0], v_i[7:5]} ^ {v_i[3:0], v_i[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] f_sub_bytes(input logic [127:0] s);
        logic [127:0] v_o;
        for (int i = 0; i < 16; i++)
            v_o[8*i +: 8] = f_sbox(s[8*i +: 8]);
        return v_o;
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [127:0] f_shift_rows(input logic [127:0] s);
        logic [127:0] v_o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                v_o[32*c+8*r +: 8] = s[32*((c+r)%4)+8*r +: 8];
        return v_o;
    endfunction

    function automatic logic [127:0] f_mix_columns(input logic [127:0] s);
        logic [127:0] v_o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            v_o[32*c +: 8]    = f_xtime(a0) ^ f_xtime(a1) ^ a1 ^ a2 ^ a3;
            v_o[32*c+8 +: 8]  = a0 ^ f_xtime(a1) ^ f_xtime(a2) ^ a2 ^ a3;
            v_o[32*c+16 +: 8] = a0 ^ a1 ^ f_xtime(a2) ^ f_xtime(a3) ^ a3;
            v_o[32*c+24 +: 8] = f_xtime(a0) ^ a0 ^ a1 ^ a2 ^ f_xtime(a3);
        end
        return v_o;
    endfunction

    assign w_sb         = f_sub_bytes(r_state);
    assign w_sr         = f_shift_rows(w_sb);
    assign w_mc         = f_mix_columns(w_sr);
    assign w_round_full = w_mc ^ key_data;
    assign w_round_last = w_sr ^ key_data;

    // Round sequencer with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_cnt       <= 4'd0;
            r_state     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_key_req   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state    <= in_data;
                        r_cnt      <= 4'd0;
                        r_fsm      <= S_ADDK0;
                        r_in_ready <= 1'b0;
                        r_key_req  <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_ADDK0: begin
                    if (key_valid) begin
                        r_state <= r_state ^ key_data;
                        r_cnt   <= 4'd1;
                        r_fsm   <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (key_valid) begin
                        r_state <= w_round_full;
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt + 4'd1 == LP_NR)
                            r_fsm <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    if (key_valid) begin
                        r_state     <= w_round_last;
                        r_fsm       <= S_DONE;
                        r_key_req   <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_fsm       <= S_IDLE;
                        r_cnt       <= 4'd0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign key_req   = r_key_req;
    assign key_round = r_cnt;
    assign busy      = r_busy;
    assign out_data  = r_state;

endmodule
